stopwatch_display_scan: RTL



---
 rtl/stopwatch_pkg.sv | 48 ++++
 rtl/stopwatch_display_scan_bcd_to_seg7.sv | 33 +++
 rtl/stopwatch_display_scan.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// ---------------------------------------------------------------------------
// stopwatch_pkg
// Shared constants for the stopwatch display path:
//   - active-low seven-segment glyphs, bit order {g,f,e,d,c,b,a}
//   - digit count, digit index width and the digit enumeration
//   - bit positions of the BCD fields inside the 20-bit TIME word (M:SS.CC)
// ---------------------------------------------------------------------------
package stopwatch_pkg;

    localparam int NUM_DIGITS  = 5;
    localparam int DIGIT_IDX_W = 3;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam int MIN_HI    = 19;
    localparam int MIN_LO    = 16;
    localparam int TENSEC_HI = 15;
    localparam int TENSEC_LO = 12;
    localparam int SEC_HI    = 11;
    localparam int SEC_LO    = 8;
    localparam int DECI_HI   = 7;
    localparam int DECI_LO   = 4;
    localparam int CENTI_HI  = 3;
    localparam int CENTI_LO  = 0;

    localparam logic [NUM_DIGITS-1:0] AN_RESET = 5'b11110;

    // Scan position doubles as the digit index: AN[n] is lit in state n.
    typedef enum logic [DIGIT_IDX_W-1:0] {
        DIG_CENTI  = 3'd0,
        DIG_DECI   = 3'd1,
        DIG_SEC    = 3'd2,
        DIG_TENSEC = 3'd3,
        DIG_MIN    = 3'd4
    } digit_e;

endpackage

// File: rtl/stopwatch_display_scan_bcd_to_seg7.sv
// ---------------------------------------------------------------------------
// bcd_to_seg7
// Combinational BCD nibble to active-low seven-segment decoder.
// Values 10..15 are not valid BCD and render as a dash.
// Ports:
//   bcd  in  4  BCD digit
//   seg  out 7  active-low cathodes {g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
module bcd_to_seg7
    import stopwatch_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/stopwatch_display_scan.sv
// ---------------------------------------------------------------------------
// stopwatch_display_scan
// Drives a 5-digit time-multiplexed common-anode seven-segment display from
// the stopwatch's packed BCD TIME word (M:SS.CC). A snapshot of TIME is taken
// once per scan frame so a frame never mixes two different times; HOLD keeps
// the current snapshot (lap freeze).
//
// Parameters:
//   REFRESH_DIV  clock cycles each digit stays lit (>= 2)
//   CNT_W        refresh counter width, 2**CNT_W >= REFRESH_DIV
// Ports:
//   CLK    in  1   system clock, rising edge
//   RESET  in  1   synchronous active-high reset
//   TIME   in  20  {MIN, TENSEC, SEC, DECISEC, CENTISEC} BCD
//   HOLD   in  1   1 = keep displayed value at frame boundaries
//   SEG    out 7   active-low cathodes {g,f,e,d,c,b,a}
//   DP     out 1   active-low decimal point
//   AN     out 5   active-low one-hot anodes, AN[0] = centiseconds
// Build option:
//   STOPWATCH_DISPLAY_LZB_EN  blank leading zero minute / ten-second digits
//
// state       | meaning
// DIG_CENTI   | AN[0] lit, centiseconds shown
// DIG_DECI    | AN[1] lit, deciseconds shown
// DIG_SEC     | AN[2] lit, seconds shown, DP lit
// DIG_TENSEC  | AN[3] lit, tens of seconds shown
// DIG_MIN     | AN[4] lit, minutes shown, DP lit
// ---------------------------------------------------------------------------
module stopwatch_display_scan
    import stopwatch_pkg::*;
#(
    parameter int REFRESH_DIV = 10000,
    parameter int CNT_W       = 14
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [19:0]           TIME,
    input  logic                  HOLD,
    output logic [6:0]            SEG,
    output logic                  DP,
    output logic [NUM_DIGITS-1:0] AN
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0]      cnt;
    logic                  wrap;
    digit_e                digit;
    digit_e                digit_next;
    logic [19:0]           snap;
    logic [19:0]           snap_next;
    logic [3:0]            nibble;
    logic [6:0]            glyph;
    logic [6:0]            seg_next;
    logic [NUM_DIGITS-1:0] an_next;
    logic                  dp_next;

    assign wrap = (cnt == CNT_LAST);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt <= '0;
        end else if (wrap) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            digit <= DIG_CENTI;
        end else begin
            digit <= digit_next;
        end
    end

    always_comb begin
        digit_next = digit;
        if (wrap) begin
            case (digit)
                DIG_CENTI:  digit_next = DIG_DECI;
                DIG_DECI:   digit_next = DIG_SEC;
                DIG_SEC:    digit_next = DIG_TENSEC;
                DIG_TENSEC: digit_next = DIG_MIN;
                DIG_MIN:    digit_next = DIG_CENTI;
                default:    digit_next = DIG_CENTI;
            endcase
        end
    end

    // Snapshot only moves at the frame boundary (wrap out of the minute digit).
    always_comb begin
        snap_next = snap;
        if (wrap && (digit == DIG_MIN) && !HOLD) begin
            snap_next = TIME;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            snap <= '0;
        end else begin
            snap <= snap_next;
        end
    end

    // Output path looks at next-state values so the registered outputs line
    // up with the index and snapshot they belong to on the same edge.
    always_comb begin
        nibble = snap_next[CENTI_HI:CENTI_LO];
        case (digit_next)
            DIG_CENTI:  nibble = snap_next[CENTI_HI:CENTI_LO];
            DIG_DECI:   nibble = snap_next[DECI_HI:DECI_LO];
            DIG_SEC:    nibble = snap_next[SEC_HI:SEC_LO];
            DIG_TENSEC: nibble = snap_next[TENSEC_HI:TENSEC_LO];
            DIG_MIN:    nibble = snap_next[MIN_HI:MIN_LO];
            default:    nibble = snap_next[CENTI_HI:CENTI_LO];
        endcase
    end

    bcd_to_seg7 u_bcd_to_seg7 (
        .bcd (nibble),
        .seg (glyph)
    );

    always_comb begin
        seg_next = glyph;
`ifdef STOPWATCH_DISPLAY_LZB_EN
        if ((digit_next == DIG_MIN) && (snap_next[MIN_HI:MIN_LO] == 4'd0)) begin
            seg_next = SEG_BLANK;
        end
        if ((digit_next == DIG_TENSEC) && (snap_next[MIN_HI:TENSEC_LO] == 8'd0)) begin
            seg_next = SEG_BLANK;
        end
`endif
    end

    always_comb begin
        an_next = 5'b11111;
        dp_next = 1'b1;
        case (digit_next)
            DIG_CENTI:  an_next = 5'b11110;
            DIG_DECI:   an_next = 5'b11101;
            DIG_SEC: begin
                an_next = 5'b11011;
                dp_next = 1'b0;
            end
            DIG_TENSEC: an_next = 5'b10111;
            DIG_MIN: begin
                an_next = 5'b01111;
                dp_next = 1'b0;
            end
            default:    an_next = 5'b11111;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            AN  <= AN_RESET;
            SEG <= SEG_0;
            DP  <= 1'b1;
        end else begin
            AN  <= an_next;
            SEG <= seg_next;
            DP  <= dp_next;
        end
    end

endmodule
